// File: rtl/modulo_rgb_ctrl_fsm.sv
`default_nettype none
// modulo_rgb_ctrl_fsm: synchronises bt/po/at, debounces bt and sequences OFF->WAIT->RUN->FAULT.
// Optional FAULT blink output is built only when MOD_RGB_BLINK_EN is defined.
module modulo_rgb_ctrl_fsm #(
  parameter int DEB_CYC   = 4,
  parameter int TIMEOUT   = 16,
  parameter int FAULT_CYC = 3,
  parameter int BLINK_DIV = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       bt_i,
  input  logic       po_i,
  input  logic       at_i,
  output logic [1:0] std_o,
  output logic       bt_q_o,
  output logic       po_s_o,
  output logic       at_s_o,
  output logic       press_o,
  output logic       blink_o
);

  localparam int DW = $clog2(DEB_CYC + 1);
  localparam int WW = $clog2(TIMEOUT + 1);
  localparam int FW = $clog2(FAULT_CYC + 1);

  if (DEB_CYC < 1 || TIMEOUT < 2 || FAULT_CYC < 1 || BLINK_DIV < 1) begin : g_bad_param
    $error("modulo_rgb_ctrl_fsm: illegal parameter value");
  end

  typedef enum logic [1:0] {
    ST_OFF   = 2'b00,
    ST_WAIT  = 2'b01,
    ST_RUN   = 2'b10,
    ST_FAULT = 2'b11
  } state_e;

  // Bit order in the sync pipeline: {at, po, bt}
  logic [2:0]    sync1_q, sync2_q;
  logic          btq_q, btq_d, btq_prev_q, press_q;
  logic [DW-1:0] deb_cnt_q, deb_cnt_d;
  state_e        state_q, state_d;
  logic [WW-1:0] wait_cnt_q, wait_cnt_d;
  logic [FW-1:0] fault_cnt_q, fault_cnt_d;
  logic          both_w;

  assign both_w = sync2_q[1] & sync2_q[2];

  always_comb begin
    deb_cnt_d = '0;
    btq_d     = btq_q;
    if (sync2_q[0] != btq_q) begin
      if (deb_cnt_q == DW'(DEB_CYC - 1)) begin
        btq_d = sync2_q[0];
      end else begin
        deb_cnt_d = deb_cnt_q + 1'b1;
      end
    end
  end

  // press has priority over every timer-driven transition
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_OFF: begin
        if (press_q) state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (press_q)                                state_d = ST_OFF;
        else if (wait_cnt_q == WW'(TIMEOUT - 1))    state_d = ST_RUN;
      end
      ST_RUN: begin
        if (press_q)                                          state_d = ST_OFF;
        else if (both_w && fault_cnt_q == FW'(FAULT_CYC - 1)) state_d = ST_FAULT;
      end
      ST_FAULT: begin
        if (press_q) state_d = ST_OFF;
      end
      default: state_d = ST_OFF;
    endcase
    wait_cnt_d  = (state_q == ST_WAIT && state_d == ST_WAIT) ? wait_cnt_q + 1'b1 : '0;
    fault_cnt_d = (state_q == ST_RUN && state_d == ST_RUN && both_w) ? fault_cnt_q + 1'b1 : '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q     <= '0;
      sync2_q     <= '0;
      btq_q       <= 1'b0;
      btq_prev_q  <= 1'b0;
      press_q     <= 1'b0;
      deb_cnt_q   <= '0;
      state_q     <= ST_OFF;
      wait_cnt_q  <= '0;
      fault_cnt_q <= '0;
    end else begin
      sync1_q     <= {at_i, po_i, bt_i};
      sync2_q     <= sync1_q;
      btq_q       <= btq_d;
      btq_prev_q  <= btq_q;
      press_q     <= btq_q & ~btq_prev_q;
      deb_cnt_q   <= deb_cnt_d;
      state_q     <= state_d;
      wait_cnt_q  <= wait_cnt_d;
      fault_cnt_q <= fault_cnt_d;
    end
  end

`ifdef MOD_RGB_BLINK_EN
  localparam int BW = $clog2(BLINK_DIV + 1);

  logic [BW-1:0] blink_cnt_q, blink_cnt_d;
  logic          blink_q, blink_d;

  always_comb begin
    blink_cnt_d = '0;
    blink_d     = 1'b0;
    if (state_d == ST_FAULT) begin
      if (state_q != ST_FAULT) begin
        blink_d = 1'b1;
      end else if (blink_cnt_q == BW'(BLINK_DIV - 1)) begin
        blink_d = ~blink_q;
      end else begin
        blink_d     = blink_q;
        blink_cnt_d = blink_cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      blink_cnt_q <= '0;
      blink_q     <= 1'b0;
    end else begin
      blink_cnt_q <= blink_cnt_d;
      blink_q     <= blink_d;
    end
  end

  assign blink_o = blink_q;
`else
  assign blink_o = 1'b0;
`endif

  assign std_o   = state_q;
  assign bt_q_o  = btq_q;
  assign po_s_o  = sync2_q[1];
  assign at_s_o  = sync2_q[2];
  assign press_o = press_q;

endmodule
`default_nettype wire

// File: tb/tb_modulo_rgb_ctrl_fsm.sv
`default_nettype none
// tb_modulo_rgb_ctrl_fsm: directed scenarios plus random stimulus against an edge-indexed reference model.
module tb_modulo_rgb_ctrl_fsm;

  localparam int DEB_CYC   = 4;
  localparam int TIMEOUT   = 16;
  localparam int FAULT_CYC = 3;
  localparam int BLINK_DIV = 8;
  localparam int MAXC      = 8192;

  logic       clk = 1'b0;
  logic       rst, bt, po, at;
  logic [1:0] std;
  logic       bt_q, po_s, at_s, press, blink;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  modulo_rgb_ctrl_fsm #(
    .DEB_CYC(DEB_CYC), .TIMEOUT(TIMEOUT), .FAULT_CYC(FAULT_CYC), .BLINK_DIV(BLINK_DIV)
  ) u_dut (
    .clk(clk), .rst(rst), .bt_i(bt), .po_i(po), .at_i(at),
    .std_o(std), .bt_q_o(bt_q), .po_s_o(po_s), .at_s_o(at_s),
    .press_o(press), .blink_o(blink)
  );

  // Raw input values seen at rising edge n, and model outputs valid just after edge n
  bit raw_bt[MAXC];
  bit raw_po[MAXC];
  bit raw_at[MAXC];
  bit m_btq[MAXC];
  bit m_press[MAXC];
  bit m_blink[MAXC];
  int m_st[MAXC];
  int n = 0;
  int r0 = 0;
  int last_flip = 0;
  int entry = 0;

  task automatic check_val(input string tag, input int obs, input int exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s @edge %0d: got %0d expected %0d", tag, n, obs, exp);
    end
  endtask

  function automatic bit rv(input int which, input int m);
    if (m <= r0 || m < 1) return 1'b0;
    case (which)
      0:       return raw_bt[m];
      1:       return raw_po[m];
      default: return raw_at[m];
    endcase
  endfunction

  task automatic model_edge();
    bit cur, flip, p, all_both;
    int st, nst;
    // bt_q flips once the last DEB_CYC synced samples (all after the previous flip) disagree with it
    cur  = m_btq[n-1];
    flip = (n - last_flip >= DEB_CYC);
    for (int k = n - DEB_CYC + 1; k <= n; k++)
      if (rv(0, k - 2) == cur) flip = 1'b0;
    m_btq[n] = flip ? ~cur : cur;
    if (flip) last_flip = n;
    m_press[n] = m_btq[n-1] & ~m_btq[n-2];

    p   = m_press[n-1];
    st  = m_st[n-1];
    nst = st;
    all_both = (n - entry >= FAULT_CYC);
    for (int k = n - FAULT_CYC + 1; k <= n; k++)
      if (!(rv(1, k - 2) && rv(2, k - 2))) all_both = 1'b0;
    case (st)
      0: if (p) nst = 1;
      1: if (p) nst = 0; else if (n - entry == TIMEOUT) nst = 2;
      2: if (p) nst = 0; else if (all_both) nst = 3;
      default: if (p) nst = 0;
    endcase
    if (nst != st) entry = n;
    m_st[n] = nst;
`ifdef MOD_RGB_BLINK_EN
    m_blink[n] = (nst == 3) && (((n - entry) / BLINK_DIV) % 2 == 0);
`else
    m_blink[n] = 1'b0;
`endif
  endtask

  task automatic tick();
    @(posedge clk);
    n++;
    if (n >= MAXC) begin
      $display("FAIL edge_budget: got %0d expected below %0d", n, MAXC);
      $fatal(1, "edge budget exceeded");
    end
    raw_bt[n] = bt;
    raw_po[n] = po;
    raw_at[n] = at;
    if (rst) begin
      r0 = n; last_flip = n; entry = n;
      m_btq[n] = 1'b0; m_press[n] = 1'b0; m_st[n] = 0; m_blink[n] = 1'b0;
    end else begin
      model_edge();
    end
    @(negedge clk);
    check_val("std",   int'(std),   m_st[n]);
    check_val("bt_q",  int'(bt_q),  int'(m_btq[n]));
    check_val("press", int'(press), int'(m_press[n]));
    check_val("po_s",  int'(po_s),  int'(rv(1, n - 1)));
    check_val("at_s",  int'(at_s),  int'(rv(2, n - 1)));
    check_val("blink", int'(blink), int'(m_blink[n]));
  endtask

  task automatic do_press();
    bt = 1'b1;
    repeat (8) tick();
    bt = 1'b0;
    repeat (8) tick();
  endtask

  task automatic wait_for_run();
    int cnt;
    cnt = 0;
    while (std != 2'b10 && cnt < 40) begin
      tick();
      cnt++;
    end
    check_val("reach_run", int'(std), 2);
  endtask

  initial begin
    int cnt;
    int len;
    rst = 1'b1; bt = 1'b0; po = 1'b0; at = 1'b0;
    repeat (3) tick();
    rst = 1'b0;
    tick();

    // glitch shorter than DEB_CYC is ignored
    bt = 1'b1;
    repeat (3) tick();
    bt = 1'b0;
    repeat (10) tick();
    check_val("glitch_btq", int'(bt_q), 0);
    check_val("glitch_std", int'(std), 0);

    // clean press: bt_q at 6, press at 7, WAIT at 8
    bt = 1'b1;
    repeat (6) tick();
    check_val("deb_btq6", int'(bt_q), 1);
    tick();
    check_val("press7", int'(press), 1);
    tick();
    check_val("wait8", int'(std), 1);
    bt = 1'b0;

    // WAIT times out to RUN after exactly TIMEOUT cycles
    cnt = 0;
    while (std == 2'b01 && cnt < 40) begin
      tick();
      cnt++;
    end
    check_val("wait_len", cnt, TIMEOUT);
    check_val("run_std", int'(std), 2);

    // sustained po&at: FAULT after 2 + FAULT_CYC cycles
    po = 1'b1; at = 1'b1;
    repeat (4) tick();
    check_val("run_hold4", int'(std), 2);
    tick();
    check_val("fault5", int'(std), 3);
    repeat (20) tick();
    po = 1'b0; at = 1'b0;
    do_press();
    check_val("fault_exit", int'(std), 0);

    // press coincides with fault threshold: OFF wins
    do_press();
    wait_for_run();
    repeat (4) tick();
    bt = 1'b1;
    repeat (3) tick();
    po = 1'b1; at = 1'b1;
    repeat (5) tick();
    check_val("press_vs_fault", int'(std), 0);
    bt = 1'b0; po = 1'b0; at = 1'b0;
    repeat (10) tick();

    // async reset in RUN with bt held high
    do_press();
    wait_for_run();
    bt = 1'b1;
    repeat (2) tick();
    #2 rst = 1'b1;
    #1;
    check_val("rst_std",   int'(std),   0);
    check_val("rst_btq",   int'(bt_q),  0);
    check_val("rst_press", int'(press), 0);
    bt = 1'b0;
    repeat (2) tick();
    rst = 1'b0;
    repeat (20) tick();
    check_val("rst_stay_off", int'(std), 0);

    // random segments
    for (int seg = 0; seg < 120; seg++) begin
      if ($urandom_range(0, 39) == 0) begin
        rst = 1'b1;
        repeat (2) tick();
        rst = 1'b0;
      end
      bt = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 1) == 1) begin
        po = 1'b1; at = 1'b1;
      end else begin
        po = 1'($urandom_range(0, 1));
        at = 1'($urandom_range(0, 1));
      end
      len = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 3)) : int'($urandom_range(4, 30));
      repeat (len) tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
